ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_pkg.sv | 24 ++
 rtl/ex_alu.sv | 42 ++++
 rtl/ex_stage.sv | 120 ++++++++++++
 tb/tb_ex_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcode enumeration and default datapath width.
package ex_pkg;

    localparam int EX_WIDTH = 64;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    function automatic logic is_all_zero(input logic [EX_WIDTH-1:0] value, input int width);
        logic acc;
        acc = 1'b1;
        for (int i = 0; i < EX_WIDTH; i++) begin
            if (i < width && value[i]) begin
                acc = 1'b0;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage: add, subtract, and, or with zero detect.
module ex_alu
    import ex_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    alu_op_e          op;

    assign op = alu_op_e'(alu_op);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic_bits
            assign and_bits[gi] = a[gi] & b[gi];
            assign or_bits[gi]  = a[gi] | b[gi];
        end
    endgenerate

    // Carry and overflow are intentionally discarded; results wrap modulo 2^WIDTH.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = and_bits;
            ALU_OR:  result = or_bits;
            default: result = '0;
        endcase
    end

    assign zero = ~|result;

endmodule

// File: rtl/ex_stage.sv
// Execute pipeline stage: ALU, branch target and PC+4 adders, and the EX/MEM pipeline register.
module ex_stage
    import ex_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [WIDTH-1:0] imm,
    input  logic             alu_src,
    input  logic [1:0]       alu_op,
    input  logic             branch,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             reg_write,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] store_data,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pc_src,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic             mem_to_reg_out,
    output logic             reg_write_out,
    output logic [4:0]       rd_out
);

    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] alu_result_next;
    logic             alu_zero_next;
    logic [WIDTH-1:0] branch_target_next;
    logic [WIDTH-1:0] pc_plus4_next;
    logic             pc_src_next;

    logic [WIDTH-1:0] alu_result_reg;
    logic             zero_reg;
    logic [WIDTH-1:0] store_data_reg;
    logic [WIDTH-1:0] branch_target_reg;
    logic [WIDTH-1:0] pc_plus4_reg;
    logic             pc_src_reg;
    logic             mem_read_reg;
    logic             mem_write_reg;
    logic             mem_to_reg_reg;
    logic             reg_write_reg;
    logic [4:0]       rd_reg;

    assign operand_b = alu_src ? imm : rs2_data;

    ex_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (rs1_data),
        .b      (operand_b),
        .alu_op (alu_op),
        .result (alu_result_next),
        .zero   (alu_zero_next)
    );

    // Both adders wrap; the shifted-out immediate MSB is simply lost.
    assign branch_target_next = pc_in + {imm[WIDTH-2:0], 1'b0};
    assign pc_plus4_next      = pc_in + WIDTH'(4);
    assign pc_src_next        = branch & alu_zero_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_result_reg    <= '0;
            zero_reg          <= 1'b0;
            store_data_reg    <= '0;
            branch_target_reg <= '0;
            pc_plus4_reg      <= '0;
            pc_src_reg        <= 1'b0;
            mem_read_reg      <= 1'b0;
            mem_write_reg     <= 1'b0;
            mem_to_reg_reg    <= 1'b0;
            reg_write_reg     <= 1'b0;
            rd_reg            <= '0;
        end else begin
            alu_result_reg    <= alu_result_next;
            zero_reg          <= alu_zero_next;
            store_data_reg    <= rs2_data;
            branch_target_reg <= branch_target_next;
            pc_plus4_reg      <= pc_plus4_next;
            rd_reg            <= rd_in;
            // A flushed instruction keeps its datapath values but loses all side effects.
            if (flush) begin
                pc_src_reg     <= 1'b0;
                mem_read_reg   <= 1'b0;
                mem_write_reg  <= 1'b0;
                mem_to_reg_reg <= 1'b0;
                reg_write_reg  <= 1'b0;
            end else begin
                pc_src_reg     <= pc_src_next;
                mem_read_reg   <= mem_read;
                mem_write_reg  <= mem_write;
                mem_to_reg_reg <= mem_to_reg;
                reg_write_reg  <= reg_write;
            end
        end
    end

    assign alu_result     = alu_result_reg;
    assign zero           = zero_reg;
    assign store_data     = store_data_reg;
    assign branch_target  = branch_target_reg;
    assign pc_plus4       = pc_plus4_reg;
    assign pc_src         = pc_src_reg;
    assign mem_read_out   = mem_read_reg;
    assign mem_write_out  = mem_write_reg;
    assign mem_to_reg_out = mem_to_reg_reg;
    assign reg_write_out  = reg_write_reg;
    assign rd_out         = rd_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected outputs are queued when inputs are driven and popped one edge later.
module tb_ex_stage;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic [W-1:0] pc_in, rs1_data, rs2_data, imm;
    logic         alu_src;
    logic [1:0]   alu_op;
    logic         branch, mem_read, mem_write, mem_to_reg, reg_write;
    logic [4:0]   rd_in;
    logic         flush;
    logic [W-1:0] alu_result, store_data, branch_target, pc_plus4;
    logic         zero, pc_src, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out;
    logic [4:0]   rd_out;

    typedef struct {
        logic [W-1:0] alu_result;
        logic         zero;
        logic [W-1:0] store_data;
        logic [W-1:0] branch_target;
        logic [W-1:0] pc_plus4;
        logic         pc_src;
        logic         mem_read;
        logic         mem_write;
        logic         mem_to_reg;
        logic         reg_write;
        logic [4:0]   rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    ex_stage #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .imm            (imm),
        .alu_src        (alu_src),
        .alu_op         (alu_op),
        .branch         (branch),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_to_reg     (mem_to_reg),
        .reg_write      (reg_write),
        .rd_in          (rd_in),
        .flush          (flush),
        .alu_result     (alu_result),
        .zero           (zero),
        .store_data     (store_data),
        .branch_target  (branch_target),
        .pc_plus4       (pc_plus4),
        .pc_src         (pc_src),
        .mem_read_out   (mem_read_out),
        .mem_write_out  (mem_write_out),
        .mem_to_reg_out (mem_to_reg_out),
        .reg_write_out  (reg_write_out),
        .rd_out         (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference behaviour written from the interface description, not from the RTL.
    function automatic exp_t model();
        exp_t         e;
        logic [W-1:0] b;
        logic [W-1:0] r;
        b = alu_src ? imm : rs2_data;
        unique case (alu_op)
            2'b00:   r = rs1_data + b;
            2'b01:   r = rs1_data - b;
            2'b10:   r = rs1_data & b;
            default: r = rs1_data | b;
        endcase
        e.alu_result    = r;
        e.zero          = (r == '0);
        e.store_data    = rs2_data;
        e.branch_target = pc_in + (imm << 1);
        e.pc_plus4      = pc_in + 64'd4;
        e.pc_src        = branch && (r == '0) && !flush;
        e.mem_read      = mem_read && !flush;
        e.mem_write     = mem_write && !flush;
        e.mem_to_reg    = mem_to_reg && !flush;
        e.reg_write     = reg_write && !flush;
        e.rd            = rd_in;
        if (!rst) begin
            e.alu_result    = '0;
            e.zero          = 1'b0;
            e.store_data    = '0;
            e.branch_target = '0;
            e.pc_plus4      = '0;
            e.pc_src        = 1'b0;
            e.mem_read      = 1'b0;
            e.mem_write     = 1'b0;
            e.mem_to_reg    = 1'b0;
            e.reg_write     = 1'b0;
            e.rd            = '0;
        end
        return e;
    endfunction

    task automatic do_txn(input string name);
        exp_t e;
        sb.push_back(model());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        txn++;
        $display("txn %0d %s: rst=%0b flush=%0b op=%0d alu_result=%h zero=%0b pc_src=%0b pc_plus4=%h",
                 txn, name, rst, flush, alu_op, alu_result, zero, pc_src, pc_plus4);
        chk({name, ".alu_result"}, alu_result, e.alu_result);
        chk({name, ".zero"}, W'(zero), W'(e.zero));
        chk({name, ".store_data"}, store_data, e.store_data);
        chk({name, ".branch_target"}, branch_target, e.branch_target);
        chk({name, ".pc_plus4"}, pc_plus4, e.pc_plus4);
        chk({name, ".pc_src"}, W'(pc_src), W'(e.pc_src));
        chk({name, ".mem_read"}, W'(mem_read_out), W'(e.mem_read));
        chk({name, ".mem_write"}, W'(mem_write_out), W'(e.mem_write));
        chk({name, ".mem_to_reg"}, W'(mem_to_reg_out), W'(e.mem_to_reg));
        chk({name, ".reg_write"}, W'(reg_write_out), W'(e.reg_write));
        chk({name, ".rd"}, W'(rd_out), W'(e.rd));
    endtask

    task automatic set_ins(input logic [W-1:0] pc, input logic [W-1:0] r1, input logic [W-1:0] r2,
                           input logic [W-1:0] im, input logic src, input logic [1:0] op,
                           input logic br, input logic [4:0] rd);
        pc_in = pc; rs1_data = r1; rs2_data = r2; imm = im;
        alu_src = src; alu_op = op; branch = br; rd_in = rd;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0;
        mem_read = 1'b1; mem_write = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
        set_ins(64'h40, 64'd3, 64'd3, 64'd2, 1'b0, 2'b01, 1'b1, 5'd9);
        do_txn("reset0");
        do_txn("reset1");
        chk("reset.zero_is_0", W'(zero), '0);
        chk("reset.alu_result_is_0", alu_result, '0);

        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b1;
        set_ins(64'h200, 64'd5, 64'd7, 64'd100, 1'b0, 2'b00, 1'b0, 5'd3);
        do_txn("add");
        chk("add.const_result", alu_result, 64'd12);
        chk("add.const_zero", W'(zero), '0);
        chk("add.const_store", store_data, 64'd7);

        set_ins(64'h100, 64'd9, 64'd9, 64'd8, 1'b0, 2'b01, 1'b1, 5'd0);
        do_txn("sub_branch");
        chk("sub_branch.const_zero", W'(zero), 64'd1);
        chk("sub_branch.const_pc_src", W'(pc_src), 64'd1);
        chk("sub_branch.const_target", branch_target, 64'h110);
        chk("sub_branch.const_plus4", pc_plus4, 64'h104);

        set_ins(64'h0, 64'hF0, 64'hDEAD_BEEF_0000_FFFF, 64'h3C, 1'b1, 2'b10, 1'b0, 5'd4);
        do_txn("and_imm");
        chk("and_imm.const_result", alu_result, 64'h30);
        alu_op = 2'b11;
        do_txn("or_imm");
        chk("or_imm.const_result", alu_result, 64'hFC);

        set_ins('1, '1, 64'd1, 64'd0, 1'b0, 2'b00, 1'b0, 5'd31);
        do_txn("wrap");
        chk("wrap.const_plus4", pc_plus4, 64'd3);
        chk("wrap.const_zero", W'(zero), 64'd1);

        set_ins(64'h8000_0000_0000_0010, 64'd1, 64'd2, 64'h8000_0000_0000_0001, 1'b0, 2'b00, 1'b0, 5'd1);
        do_txn("target_msb_drop");
        chk("target_msb_drop.const", branch_target, 64'h8000_0000_0000_0012);

        mem_read = 1'b1; mem_write = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; flush = 1'b1;
        set_ins(64'h300, 64'd4, 64'd4, 64'd0, 1'b0, 2'b01, 1'b1, 5'd7);
        do_txn("flush");
        chk("flush.const_reg_write", W'(reg_write_out), '0);
        chk("flush.const_pc_src", W'(pc_src), '0);
        chk("flush.const_zero_datapath", W'(zero), 64'd1);
        rst = 1'b0;
        do_txn("flush_rst");
        chk("flush_rst.const_rd", W'(rd_out), '0);

        rst = 1'b1; flush = 1'b0;
        do_txn("after_reset");
        chk("after_reset.const_pc_src", W'(pc_src), 64'd1);

        for (int i = 0; i < 30; i++) begin
            set_ins({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, 1'($urandom), 2'($urandom), 1'($urandom), 5'($urandom));
            if (i % 5 == 2) rs2_data = rs1_data;
            mem_read = 1'($urandom); mem_write = 1'($urandom);
            mem_to_reg = 1'($urandom); reg_write = 1'($urandom);
            flush = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 7) != 0);
            do_txn("rand");
        end

        chk("scoreboard_empty", W'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
